fpu_sched: RTL and testbench

//  Shares one fpu instance between N_REQ requesters. Round-robin arbiter with valid/ready accept per requester.

---
 rtl/fpu_sched.sv | 147 ++++++++++++++
 tb/tb_fpu_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sched.sv
// fpu_sched: shares one fpu between N_REQ requesters.
// Round-robin grant, registered fpu operands, tag pipe that returns each
// result with its requester id, and a RUN/DRAIN/HALTED quiesce FSM.
// Optional feature macro: FPU_DIV_TRAP_EN (divides are answered with a qNaN
// instead of being sent to the fpu).
module fpu_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int FPU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [2*N_REQ-1:0]   req_op,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic [1:0]           fpu_opcode,
  input  logic [31:0]          fpu_outp,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_data,
  input  logic                 halt_req,
  output logic                 halted
);

  // Tag stage 0 sits alongside the fpu input registers; the remaining
  // FPU_LAT+1 stages follow the fpu's own sample and compute latency.
  localparam int DEPTH = FPU_LAT + 2;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [31:0]        fpu_a_q, fpu_b_q;
  logic [1:0]         fpu_op_q;
  logic [DEPTH-1:0]   tag_vld_q;
  logic [DEPTH-1:0]   tag_trap_q;
  logic [ID_W-1:0]    tag_id_q [DEPTH];

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  int                 scan_idx;
  logic               accept;
  logic               is_trap;
  logic               pipe_empty;
  logic [31:0]        sel_a, sel_b;
  logic [1:0]         sel_op;

  // Round-robin search: first valid requester after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan_idx);
      end
    end
  end

  assign accept = gnt_found && (state_q == ST_RUN);
  assign sel_a  = req_a[32*int'(gnt_idx) +: 32];
  assign sel_b  = req_b[32*int'(gnt_idx) +: 32];
  assign sel_op = req_op[2*int'(gnt_idx) +: 2];

`ifdef FPU_DIV_TRAP_EN
  assign is_trap = (sel_op == 2'b10);
`else
  assign is_trap = 1'b0;
`endif

  // One-hot grant, only while running.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Operand registers feeding the fpu; trapped divides leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a_q  <= '0;
      fpu_b_q  <= '0;
      fpu_op_q <= 2'b00;
    end else if (accept && !is_trap) begin
      fpu_a_q  <= sel_a;
      fpu_b_q  <= sel_b;
      fpu_op_q <= sel_op;
    end
  end

  // Tag shift pipe: one entry per cycle, valid only for accepted ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_trap_q <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[DEPTH-2:0], accept};
      tag_trap_q  <= {tag_trap_q[DEPTH-2:0], accept && is_trap};
      tag_id_q[0] <= accept ? gnt_idx : '0;
      for (int k = 1; k < DEPTH; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  assign pipe_empty = ~|tag_vld_q;
  assign ptr_d      = accept ? gnt_idx : ptr_q;

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Quiesce FSM: leaving halt_req low always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN:  begin
        if (!halt_req)      state_d = ST_RUN;
        else if (pipe_empty) state_d = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign resp_valid = tag_vld_q[DEPTH-1];
  assign resp_id    = tag_id_q[DEPTH-1];
  assign resp_data  = tag_trap_q[DEPTH-1] ? QNAN : fpu_outp;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fpu_sched.sv
// Testbench for fpu_sched: random and directed requests, a behavioural
// arbitration/quiesce model, an fpu stub, and a response scoreboard.
module tb_fpu_sched;

  localparam int N = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [31:0]     fpu_a, fpu_b;
  logic [1:0]      fpu_opcode;
  logic [31:0]     fpu_outp = '0;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [31:0]     resp_data;
  logic            halt_req = 1'b0;
  logic            halted;

  fpu_sched #(.N_REQ(N), .ID_W(2), .FPU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_outp(fpu_outp),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- single-precision helpers (normal numbers only) ------
  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:0] == 63'd0 || e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra, rb, r;
    ra = s2r(a);
    rb = s2r(b);
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra / rb;
      default: r = ra * rb;
    endcase
    return r2s(r);
  endfunction

  function automatic bit trapped(input logic [1:0] op);
`ifdef FPU_DIV_TRAP_EN
    return op == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- fpu stub: samples inputs, result one edge later -----
  logic [31:0] s_a = '0, s_b = '0;
  logic [1:0]  s_op = '0;
  always @(posedge clk) begin
    s_a      <= fpu_a;
    s_b      <= fpu_b;
    s_op     <= fpu_opcode;
    fpu_outp <= sp_op(s_a, s_b, s_op);
  end

  // ---------------- reference model state -------------------------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          mptr = N - 1;
  int          mstate = M_RUN;
  int          last_dec = -100;
  logic [31:0] mfa = '0, mfb = '0;
  logic [1:0]  mfop = '0;
  logic [31:0] d_a [N];
  logic [31:0] d_b [N];
  logic [1:0]  d_op [N];

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      d_a[i]  = rand_fp();
      d_b[i]  = rand_fp();
      d_op[i] = 2'($urandom);
    end
  endtask

  // One clock cycle: check held fpu registers, drive inputs, check the
  // grant against the model, record any accept, advance the model.
  task automatic step(input logic [N-1:0] v, input logic h);
    int g;
    bit empty;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    chk("fpu_a", fpu_a, mfa);
    chk("fpu_b", fpu_b, mfb);
    chk("fpu_opcode", 32'(fpu_opcode), 32'(mfop));
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = d_a[i];
      req_b[32*i +: 32] = d_b[i];
      req_op[2*i +: 2]  = d_op[i];
    end
    req_valid = v;
    halt_req  = h;
    #1;
    g = -1;
    if (mstate == M_RUN) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (mptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("halted", 32'(halted), 32'(mstate == M_HALT));
    empty = (cyc > last_dec + 3);
    if (g >= 0) begin
      exp_t e;
      e.id   = g;
      e.data = trapped(d_op[g]) ? 32'h7FC0_0000 : sp_op(d_a[g], d_b[g], d_op[g]);
      e.due  = cyc + 3;
      sb.push_back(e);
      $display("accept cyc=%0d id=%0d a=%h b=%h op=%0d expect=%h", cyc, g, d_a[g], d_b[g], d_op[g], e.data);
      mptr     = g;
      last_dec = cyc;
      if (!trapped(d_op[g])) begin
        mfa  = d_a[g];
        mfb  = d_b[g];
        mfop = d_op[g];
      end
    end
    case (mstate)
      M_RUN:   if (h) mstate = M_DRAIN;
      M_DRAIN: if (!h) mstate = M_RUN; else if (empty) mstate = M_HALT;
      default: if (!h) mstate = M_RUN;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    halt_req  = 1'b0;
    #3 rst = 1'b1;
    sb.delete();
    mptr = N - 1; mstate = M_RUN; last_dec = -100;
    mfa = '0; mfb = '0; mfop = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  // ---------------- monitor: pops the scoreboard on every response ------
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_data", resp_data, e.data);
          chk("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_missing", 32'd0, 32'd1);
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    logic h;
    logic [N-1:0] v;
    rand_ops();
    do_reset();

    // Single add from requester 0: 1.0 + 2.0.
    d_a[0] = 32'h3F80_0000; d_b[0] = 32'h4000_0000; d_op[0] = 2'b00;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    @(negedge clk);
    #2;
    chk("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_resp_id", 32'(resp_id), 32'd0);
    chk("t1_resp_data", resp_data, 32'h4040_0000);

    // All requesters pending: strict rotation, back-to-back responses.
    do_reset();
    repeat (8) begin rand_ops(); step(4'b1111, 1'b0); end
    repeat (4) step(4'b0000, 1'b0);

    // Grant to 2, then 1011 -> 3, then 0.
    rand_ops();
    step(4'b0100, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1011, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Two in flight, then halt: drain, halted, release, grant again.
    do_reset();
    rand_ops();
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    repeat (6) step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Halt with an empty pipe.
    repeat (4) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Reset with an op in flight: its response must vanish.
    rand_ops();
    step(4'b0001, 1'b0);
    do_reset();
    repeat (5) step(4'b0000, 1'b0);

    // Divide from requester 1.
    rand_ops();
    d_op[1] = 2'b10;
    step(4'b0010, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Random traffic with random halt windows.
    h = 1'b0;
    repeat (300) begin
      rand_ops();
      v = N'($urandom);
      if ($urandom_range(0, 19) == 0) h = ~h;
      step(v, h);
    end
    repeat (6) step(4'b0000, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
